// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
// Shared constants, the host FSM state type, and the load-sequencing helpers
// used by the enigma host sequencer.
//   TBL_IDX_*    : table selector values driven on the core's table_idx
//   ROTOR_SIZE   : entries per rotor table
//   LOAD_CYCLES  : length of the core's load window (rotorA + rotorB)
//   host_state_t : host sequencer FSM states
// -----------------------------------------------------------------------------
package enigma_pkg;

   localparam logic [1:0] TBL_IDX_PLUG = 2'b00;
   localparam logic [1:0] TBL_IDX_ROTA = 2'b01;
   localparam logic [1:0] TBL_IDX_ROTB = 2'b10;

   localparam int ROTOR_SIZE  = 64;
   localparam int LOAD_CYCLES = 128;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_LOAD = 2'd1,
      S_GAP  = 2'd2,
      S_RUN  = 2'd3
   } host_state_t;

   // ROM address to present after load edge k; the last address is held
   // because the final entry is already in flight from the registered ROM.
   function automatic logic [6:0] load_addr(input logic [7:0] k);
      if (k > 8'(LOAD_CYCLES - 1)) begin
         load_addr = 7'(LOAD_CYCLES - 1);
      end else begin
         load_addr = k[6:0];
      end
   endfunction

   // Table selector for the cycle after load edge k. Data lags the address
   // by one cycle, so edges 1..64 carry rotorA entries 0..63.
   function automatic logic [1:0] load_table_idx(input logic [7:0] k);
      if (k <= 8'(ROTOR_SIZE)) begin
         load_table_idx = TBL_IDX_ROTA;
      end else begin
         load_table_idx = TBL_IDX_ROTB;
      end
   endfunction

endpackage

// File: rtl/enigma_res_fifo.sv
// -----------------------------------------------------------------------------
// enigma_res_fifo
// Synchronous first-word-fall-through FIFO holding core results.
//   clk, srst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata : write request and data
//   pop         : read request; ignored when empty
//   rdata       : head entry (valid whenever empty is low)
//   count       : number of stored entries, 0..DEPTH
//   empty       : no entries stored
// -----------------------------------------------------------------------------
module enigma_res_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     srst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & (count_r != '0);
   // A push into a full FIFO is only accepted when a pop frees a slot.
   assign do_push = push & ((count_r != CW'(DEPTH)) | do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == '0);

endmodule

// File: rtl/enigma_host_seq.sv
// -----------------------------------------------------------------------------
// enigma_host_seq
// Host-side sequencer for the enigma_part2 core. After reset it streams the
// rotorA and rotorB tables from a registered table ROM through the core's
// 128-cycle load window, then forwards upstream symbols as encrypt pulses and
// queues the core's results in a FWFT FIFO behind a valid/ready handshake.
//   clk, srst_n          : clock, synchronous active-low reset
//   tbl_addr / tbl_data  : table ROM address out, data in (one cycle later)
//   in_valid/in_ready    : upstream symbol handshake; in_code, in_mode
//   out_valid/out_ready  : result handshake; out_code
//   en_*                 : core load/encrypt interface
//   load_done            : run phase active
//   err                  : sticky, a result was captured without code_valid
// -----------------------------------------------------------------------------
module enigma_host_seq
   import enigma_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       srst_n,
   output logic [6:0] tbl_addr,
   input  logic [5:0] tbl_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] in_code,
   input  logic       in_mode,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_code,
   output logic       en_load,
   output logic [1:0] en_table_idx,
   output logic [5:0] en_code_in,
   output logic       en_encrypt,
   output logic       en_crypt_mode,
   input  logic [5:0] en_code_out,
   input  logic       en_code_valid,
   output logic       load_done,
   output logic       err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   host_state_t state_r, state_nx;

   logic [7:0]    ld_cnt_r,        ld_cnt_nx;
   logic [6:0]    tbl_addr_r,      tbl_addr_nx;
   logic          en_load_r,       en_load_nx;
   logic [1:0]    en_table_idx_r,  en_table_idx_nx;
   logic [5:0]    en_code_in_r,    en_code_in_nx;
   logic          en_encrypt_r,    en_encrypt_nx;
   logic          en_crypt_mode_r, en_crypt_mode_nx;
   logic          load_done_r,     load_done_nx;
   logic          cap_v_r;
   logic          err_r;

   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic [5:0]    fifo_head;
   logic [CW-1:0] credit;
   logic          hs;

   // Every issued encrypt owns a FIFO slot from issue until it lands, so
   // credit counts both stored results and the two pipeline stages.
   assign credit   = fifo_count + CW'(en_encrypt_r) + CW'(cap_v_r);
   assign in_ready = load_done_r & (credit < CW'(FIFO_DEPTH));
   assign hs       = in_valid & in_ready;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         state_r <= S_WAIT;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state and next-output logic for load sequencing and symbol issue.
   always_comb begin
      state_nx         = state_r;
      ld_cnt_nx        = ld_cnt_r;
      tbl_addr_nx      = tbl_addr_r;
      en_load_nx       = 1'b0;
      en_table_idx_nx  = TBL_IDX_PLUG;
      en_code_in_nx    = en_code_in_r;
      en_encrypt_nx    = 1'b0;
      en_crypt_mode_nx = en_crypt_mode_r;
      load_done_nx     = load_done_r;
      case (state_r)
         S_WAIT: begin
            state_nx        = S_LOAD;
            ld_cnt_nx       = 8'd1;
            tbl_addr_nx     = load_addr(8'd1);
            en_load_nx      = 1'b1;
            en_table_idx_nx = load_table_idx(8'd1);
         end
         S_LOAD: begin
            if (ld_cnt_r == 8'(LOAD_CYCLES)) begin
               state_nx      = S_GAP;
               en_code_in_nx = 6'd0;
            end else begin
               ld_cnt_nx       = ld_cnt_r + 8'd1;
               tbl_addr_nx     = load_addr(ld_cnt_r + 8'd1);
               en_load_nx      = 1'b1;
               en_table_idx_nx = load_table_idx(ld_cnt_r + 8'd1);
            end
         end
         S_GAP: begin
            state_nx     = S_RUN;
            load_done_nx = 1'b1;
         end
         S_RUN: begin
            if (hs) begin
               en_encrypt_nx    = 1'b1;
               en_code_in_nx    = in_code;
               en_crypt_mode_nx = in_mode;
            end else begin
               en_encrypt_nx    = 1'b0;
            end
         end
         default: begin
            state_nx = S_WAIT;
         end
      endcase
   end

   // Registered core-interface and status outputs.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         ld_cnt_r        <= 8'd0;
         tbl_addr_r      <= 7'd0;
         en_load_r       <= 1'b0;
         en_table_idx_r  <= TBL_IDX_PLUG;
         en_code_in_r    <= 6'd0;
         en_encrypt_r    <= 1'b0;
         en_crypt_mode_r <= 1'b0;
         load_done_r     <= 1'b0;
      end else begin
         ld_cnt_r        <= ld_cnt_nx;
         tbl_addr_r      <= tbl_addr_nx;
         en_load_r       <= en_load_nx;
         en_table_idx_r  <= en_table_idx_nx;
         en_code_in_r    <= en_code_in_nx;
         en_encrypt_r    <= en_encrypt_nx;
         en_crypt_mode_r <= en_crypt_mode_nx;
         load_done_r     <= load_done_nx;
      end
   end

   // Capture pipeline: the core registers its result one edge after the
   // encrypt pulse, so the result is pushed one edge after that.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         cap_v_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         cap_v_r <= en_encrypt_r;
         err_r   <= err_r | (cap_v_r & ~en_code_valid);
      end
   end

   enigma_res_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (6)
   ) u_res_fifo (
      .clk    (clk),
      .srst_n (srst_n),
      .push   (cap_v_r),
      .wdata  (en_code_out),
      .pop    (out_ready),
      .rdata  (fifo_head),
      .count  (fifo_count),
      .empty  (fifo_empty)
   );

   // During load the ROM data goes straight to the core; the ROM is
   // already registered, so adding a register here would cost a cycle.
   assign en_code_in    = (state_r == S_LOAD) ? tbl_data : en_code_in_r;
   assign tbl_addr      = tbl_addr_r;
   assign en_load       = en_load_r;
   assign en_table_idx  = en_table_idx_r;
   assign en_encrypt    = en_encrypt_r;
   assign en_crypt_mode = en_crypt_mode_r;
   assign load_done     = load_done_r;
   assign err           = err_r;
   assign out_valid     = ~fifo_empty;
   assign out_code      = fifo_head;

endmodule

// File: tb/tb_enigma_host_seq.sv
// -----------------------------------------------------------------------------
// tb_enigma_host_seq
// Self-checking bench for enigma_host_seq. Models the registered table ROM and
// a stand-in core whose result is a fixed function of (code, mode), registered
// one edge after the encrypt pulse. Expected results go into a scoreboard
// queue at issue time and are compared when the DUT hands them downstream.
// -----------------------------------------------------------------------------
module tb_enigma_host_seq;

   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       srst_n;
   logic [6:0] tbl_addr;
   logic [5:0] tbl_data = 6'd0;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_code;
   logic       in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_code;
   logic       en_load;
   logic [1:0] en_table_idx;
   logic [5:0] en_code_in;
   logic       en_encrypt;
   logic       en_crypt_mode;
   logic [5:0] core_out = 6'd0;
   logic       core_valid;
   logic       load_done;
   logic       err;

   logic [5:0] rom [128];
   logic [5:0] sb [$];
   int         errors = 0;
   int         checks = 0;
   int         edge_no = 0;

   enigma_host_seq #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk           (clk),
      .srst_n        (srst_n),
      .tbl_addr      (tbl_addr),
      .tbl_data      (tbl_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_code       (in_code),
      .in_mode       (in_mode),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_code      (out_code),
      .en_load       (en_load),
      .en_table_idx  (en_table_idx),
      .en_code_in    (en_code_in),
      .en_encrypt    (en_encrypt),
      .en_crypt_mode (en_crypt_mode),
      .en_code_out   (core_out),
      .en_code_valid (core_valid),
      .load_done     (load_done),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Stand-in core transfer function.
   function automatic logic [5:0] core_f(input logic [5:0] code, input logic mode);
      if (mode) core_f = code ^ 6'h2A;
      else      core_f = 6'd63 - code;
   endfunction

   // Registered table ROM.
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   // Stand-in core: result registered one edge after the encrypt pulse.
   always @(posedge clk) if (en_encrypt) core_out <= core_f(en_code_in, en_crypt_mode);

   // Scoreboard: compare each result as it is accepted downstream.
   always @(negedge clk) begin
      if (srst_n && out_valid && out_ready) begin
         checks++;
         assert (sb.size() != 0)
            else begin errors++; $error("FAIL sb_extra: observed=%0d expected=no result", out_code); end
         if (sb.size() != 0) begin
            logic [5:0] exp_v;
            exp_v = sb.pop_front();
            checks++;
            assert (out_code === exp_v)
               else begin errors++; $error("FAIL sb_code: observed=%0d expected=%0d", out_code, exp_v); end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
         else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v); end
   endtask

   task automatic tick();
      @(posedge clk);
      if (srst_n) edge_no++;
      else        edge_no = 0;
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_en_load"},  en_load, 0);
      chk({tag, "_tbl_addr"}, tbl_addr, 0);
      chk({tag, "_idx"},      en_table_idx, 0);
      chk({tag, "_encrypt"},  en_encrypt, 0);
      chk({tag, "_load_done"}, load_done, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_err"},      err, 0);
   endtask

   task automatic check_load(input int last);
      for (int k = 1; k <= last; k++) begin
         tick();
         chk("ld_en",   en_load, 1);
         chk("ld_idx",  en_table_idx, (k <= 64) ? 1 : 2);
         chk("ld_code", en_code_in, rom[k-1]);
         chk("ld_addr", tbl_addr, (k < 128) ? k : 127);
         chk("ld_rdy",  in_ready, 0);
      end
   endtask

   task automatic full_load();
      check_load(128);
      tick();
      chk("gap_en_load", en_load, 0);
      chk("gap_idx",     en_table_idx, 0);
      chk("gap_code",    en_code_in, 0);
      chk("gap_done",    load_done, 0);
      chk("gap_rdy",     in_ready, 0);
      tick();
      chk("run_edge",    edge_no, 130);
      chk("run_done",    load_done, 1);
      chk("run_rdy",     in_ready, 1);
   endtask

   task automatic send(input int n, input int budget, output int sent, output int cycles);
      logic [5:0] code;
      logic       mode;
      logic       take;
      sent = 0; cycles = 0; code = 6'd0; mode = 1'b0;
      while (sent < n && cycles < budget) begin
         if (!in_valid) begin
            code = 6'($urandom_range(0, 63));
            mode = 1'($urandom_range(0, 1));
            in_code = code; in_mode = mode; in_valid = 1'b1;
         end
         take = in_ready;
         if (take) sb.push_back(core_f(code, mode));
         tick();
         cycles++;
         if (take) begin
            sent++;
            in_valid = 1'b0;
            chk("enc_pulse", en_encrypt, 1);
            chk("enc_code",  en_code_in, code);
            chk("enc_mode",  en_crypt_mode, mode);
         end else begin
            chk("enc_idle",  en_encrypt, 0);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin tick(); n++; end
      chk({tag, "_left"}, sb.size(), 0);
      tick();
      chk({tag, "_ovalid"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sent, cyc, guard;
      srst_n = 1'b0; in_valid = 1'b0; in_code = 6'd0; in_mode = 1'b0;
      out_ready = 1'b0; core_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         rom[i]      = 6'(i);
         rom[i + 64] = 6'(63 - i);
      end

      // Reset and the first full table load.
      repeat (3) tick();
      check_reset_vals("rst");
      srst_n = 1'b1;
      full_load();

      // Streaming: 16 back-to-back symbols.
      out_ready = 1'b1;
      send(16, 40, sent, cyc);
      chk("stream_sent", sent, 16);
      chk("stream_cycles", cyc, 16);
      drain("stream");
      chk("stream_err", err, 0);

      // Backpressure: only FIFO_DEPTH symbols accepted while stalled.
      out_ready = 1'b0;
      send(6, 10, sent, cyc);
      chk("bp_sent", sent, FIFO_DEPTH);
      chk("bp_rdy", in_ready, 0);
      chk("bp_ovalid", out_valid, 1);
      out_ready = 1'b1;
      send(2, 20, sent, cyc);
      chk("bp_rest", sent, 2);
      drain("bp");

      // Simultaneous push and pop with FIFO_DEPTH-1 entries stored.
      out_ready = 1'b0;
      send(FIFO_DEPTH - 1, 10, sent, cyc);
      repeat (3) tick();
      chk("pp_rdy3", in_ready, 1);
      in_code = 6'd17; in_mode = 1'b1; in_valid = 1'b1;
      sb.push_back(core_f(6'd17, 1'b1));
      tick();
      in_valid = 1'b0;
      chk("pp_full_rdy", in_ready, 0);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pp_hold_rdy", in_ready, 1);
      chk("pp_ovalid", out_valid, 1);
      chk("pp_sbsize", sb.size(), FIFO_DEPTH - 1);
      drain("pp");

      // Mid-run reset with 3 queued results, captured without code_valid.
      out_ready = 1'b0;
      core_valid = 1'b0;
      send(3, 10, sent, cyc);
      repeat (3) tick();
      chk("err_set", err, 1);
      core_valid = 1'b1;
      srst_n = 1'b0;
      sb.delete();
      tick();
      check_reset_vals("run_rst");
      tick();
      srst_n = 1'b1;

      // Reload, reset at edge 60, then reload identity tables.
      check_load(59);
      srst_n = 1'b0;
      for (int i = 0; i < 128; i++) rom[i] = 6'(i % 64);
      tick();
      check_reset_vals("ld_rst");
      tick();
      srst_n = 1'b1;
      full_load();

      // First symbol: handshake at edge 140, result visible after edge 142.
      guard = 0;
      while (edge_no < 139 && guard < 20) begin tick(); guard++; end
      in_code = 6'd5; in_mode = 1'b0; in_valid = 1'b1;
      chk("fs_rdy", in_ready, 1);
      sb.push_back(6'd58);
      tick();
      in_valid = 1'b0;
      chk("fs_edge", edge_no, 140);
      chk("fs_enc", en_encrypt, 1);
      chk("fs_code", en_code_in, 5);
      chk("fs_mode", en_crypt_mode, 0);
      chk("fs_ov140", out_valid, 0);
      tick();
      chk("fs_enc141", en_encrypt, 0);
      chk("fs_ov141", out_valid, 0);
      tick();
      chk("fs_ov142", out_valid, 1);
      chk("fs_out", out_code, 58);
      chk("fs_err", err, 0);
      drain("fs");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
